// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with LSB first and an idle-high line.
// RX passes through a two-flop synchronizer. A falling edge starts a frame.
// The start bit is qualified at its centre, and every data and stop bit is
// sampled at its centre. The received byte is handed to the consumer with a
// rdy/clr_rdy handshake, together with sticky framing and overrun flags.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   When defined, each sample is a 2-of-3 vote over centre-1, centre and
//   centre+1. The frame as a whole slips by one clock.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   RX       serial line (asynchronous, idle high)
//   clr_rdy  one-cycle pulse from the consumer: clears rdy, frm_err, ovr_err
//   rx_data  last received byte
//   rdy      byte valid; held until clr_rdy
//   frm_err  sticky: stop bit sampled low
//   ovr_err  sticky: a byte completed while rdy was still set
module uart_rx #(
  parameter int unsigned BAUD_CNT = 5208,
  parameter int unsigned HALF_CNT = BAUD_CNT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned OFS = 1;
`else
  localparam int unsigned OFS = 0;
`endif

  // The start-bit decision moves one clock later in majority mode. Because the
  // counter is cleared at that later point, the data and stop decisions stay at
  // BAUD_CNT-1, and the total slip is a single clock.
  localparam logic [12:0] START_DEC = 13'(HALF_CNT - 1 + OFS);
  localparam logic [12:0] BIT_DEC   = 13'(BAUD_CNT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  state_t      state, state_nxt;
  logic        rx_meta, rx_s, rx_prev;
  logic [1:0]  fill;
  logic        armed;
  logic        fall;
  logic [12:0] cnt;
  logic [12:0] dec_cnt;
  logic        at_dec;
  logic        bit_val;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        done;
  logic        cnt_clr, shift_en, bit_clr, done_set, frm_set;

  // The synchronizer flops preset to 1. The fill/armed pair ignores start
  // edges until a genuinely synchronized high has been seen after reset. This
  // means a frame already in flight at release is not decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      fill    <= '0;
      armed   <= 1'b0;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      fill    <= {fill[0], 1'b1};
      if (fill[1] && rx_s) armed <= 1'b1;
    end
  end

  assign fall    = armed & rx_prev & ~rx_s;
  assign dec_cnt = (state == START) ? START_DEC : BIT_DEC;
  assign at_dec  = (cnt == dec_cnt);

`ifdef UART_RX_MAJORITY_EN
  logic s_early, s_mid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_early <= 1'b0;
      s_mid   <= 1'b0;
    end else begin
      if (cnt == dec_cnt - 13'd2) s_early <= rx_s;
      if (cnt == dec_cnt - 13'd1) s_mid   <= rx_s;
    end
  end

  assign bit_val = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    bit_clr   = 1'b0;
    done_set  = 1'b0;
    frm_set   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (fall) begin
          state_nxt = START;
          bit_clr   = 1'b1;
        end
      end
      START: begin
        if (at_dec) begin
          cnt_clr   = 1'b1;
          state_nxt = bit_val ? IDLE : DATA;
        end
      end
      DATA: begin
        if (at_dec) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 4'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (at_dec) begin
          cnt_clr = 1'b1;
          if (bit_val) begin
            done_set  = 1'b1;
            state_nxt = IDLE;
          end else begin
            frm_set   = 1'b1;
            state_nxt = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        cnt_clr = 1'b1;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else              cnt <= cnt + 13'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      done      <= 1'b0;
    end else begin
      done <= done_set;
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift_reg <= {bit_val, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 4'd1;
      end
    end
  end

  // A completion in the same cycle as clr_rdy wins. rdy stays set and no
  // overrun is flagged, because the consumer has just taken the old byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      if (done) rx_data <= shift_reg;

      if (done)         rdy <= 1'b1;
      else if (clr_rdy) rdy <= 1'b0;

      if (done && rdy && !clr_rdy) ovr_err <= 1'b1;
      else if (clr_rdy)            ovr_err <= 1'b0;

      if (frm_set)      frm_err <= 1'b1;
      else if (clr_rdy) frm_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx with BAUD_CNT=32.
// A frame is driven one clock step at a time from a table computed by bit
// position. The expected byte, rdy and flag values come from a handshake model
// that is updated per completed frame.
module tb_uart_rx;

  localparam int B = 32;
  localparam int H = B / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int LAT = 2 + 1 + H + 9 * B + 1 + MAJ;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy, frm_err, ovr_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_data;
  logic       m_rdy, m_frm, m_ovr;

  uart_rx #(.BAUD_CNT(B)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr_err (ovr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model of the consumer-visible state.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit clr_same);
    if (stop_ok) begin
      if (m_rdy && !clr_same) m_ovr = 1'b1;
      if (clr_same) begin
        m_ovr = 1'b0;
        m_frm = 1'b0;
      end
      m_rdy  = 1'b1;
      m_data = b;
    end else begin
      m_frm = 1'b1;
    end
  endtask

  task automatic model_clr();
    m_rdy = 1'b0;
    m_frm = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Drive steps [0, nsteps) of a 10-bit frame, one clock per step. The step at
  // index glitch (if >= 0) is inverted.
  task automatic drive_frame(input logic [7:0] b, input bit stop, input int glitch, input int nsteps);
    logic lvl;
    int   seg;
    for (int s = 0; s < nsteps; s++) begin
      seg = s / B;
      if (seg == 0)      lvl = 1'b0;
      else if (seg <= 8) lvl = b[seg-1];
      else               lvl = stop;
      if (s == glitch) lvl = ~lvl;
      @(negedge clk);
      RX = lvl;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      RX = 1'b1;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    model_clr();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; RX = 1'b1; clr_rdy = 1'b0;
    model_clr();
    m_data = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rx_data, rdy, frm_err, ovr_err} !== 11'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected %h", {rx_data, rdy, frm_err, ovr_err}, 11'h0);
    end
    rst_n = 1'b1;
    idle(8);
    n_cmp++;
    if (rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_rdy: got %b expected 0", rdy);
    end
  endtask

  task automatic test_basic();
    int n;
    n = 1;
    fork
      drive_frame(8'hA5, 1'b1, -1, 10 * B);
      begin
        @(negedge clk);
        while (!rdy && n <= 12 * B) begin
          @(negedge clk);
          n++;
        end
      end
    join
    model_frame(8'hA5, 1'b1, 1'b0);
    n_cmp++;
    if ((n - 1) < LAT - 1 || (n - 1) > LAT + 1) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d expected %0d", n - 1, LAT);
    end
    n_cmp++;
    if ({rx_data, rdy, frm_err, ovr_err} !== {m_data, m_rdy, m_frm, m_ovr}) begin
      n_bad++;
      $display("FAIL basic_byte: got %h expected %h", {rx_data, rdy, frm_err, ovr_err}, {m_data, m_rdy, m_frm, m_ovr});
    end
    pulse_clr();
    n_cmp++;
    if (rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_clr: got %b expected 0", rdy);
    end
    idle(B);
  endtask

  task automatic test_back_to_back();
    logic [7:0] got0, got1;
    int         n;
    got0 = 8'hxx; got1 = 8'hxx;
    fork
      begin
        drive_frame(8'h00, 1'b1, -1, 10 * B);
        drive_frame(8'hFF, 1'b1, -1, 10 * B);
      end
      begin
        n = 0;
        while (!rdy && n < 12 * B) begin @(negedge clk); n++; end
        got0 = rx_data;
        pulse_clr();
        n = 0;
        while (!rdy && n < 12 * B) begin @(negedge clk); n++; end
        got1 = rx_data;
      end
    join
    n_cmp++;
    if (got0 !== 8'h00) begin
      n_bad++;
      $display("FAIL b2b_first: got %h expected 00", got0);
    end
    n_cmp++;
    if ({got1, rdy, frm_err, ovr_err} !== {8'hFF, 3'b100}) begin
      n_bad++;
      $display("FAIL b2b_second: got %h expected %h", {got1, rdy, frm_err, ovr_err}, {8'hFF, 3'b100});
    end
    pulse_clr();
    m_data = 8'hFF;
    idle(B);
  endtask

  task automatic test_framing();
    drive_frame(8'h3C, 1'b0, -1, 10 * B);
    model_frame(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      RX = 1'b0;
    end
    n_cmp++;
    if ({rx_data, rdy, frm_err, ovr_err} !== {m_data, m_rdy, m_frm, m_ovr}) begin
      n_bad++;
      $display("FAIL framing_flags: got %h expected %h", {rx_data, rdy, frm_err, ovr_err}, {m_data, m_rdy, m_frm, m_ovr});
    end
    idle(12 * B);
    n_cmp++;
    if ({rdy, frm_err} !== 2'b01) begin
      n_bad++;
      $display("FAIL framing_no_refire: got %b expected 01", {rdy, frm_err});
    end
    pulse_clr();
    n_cmp++;
    if (frm_err !== 1'b0) begin
      n_bad++;
      $display("FAIL framing_clr: got %b expected 0", frm_err);
    end
  endtask

  task automatic test_overrun();
    drive_frame(8'h11, 1'b1, -1, 10 * B);
    model_frame(8'h11, 1'b1, 1'b0);
    idle(B);
    drive_frame(8'h22, 1'b1, -1, 10 * B);
    model_frame(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({rx_data, rdy, frm_err, ovr_err} !== {m_data, m_rdy, m_frm, m_ovr}) begin
      n_bad++;
      $display("FAIL overrun_flags: got %h expected %h", {rx_data, rdy, frm_err, ovr_err}, {m_data, m_rdy, m_frm, m_ovr});
    end
    pulse_clr();
    n_cmp++;
    if ({rdy, ovr_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL overrun_clr: got %b expected 00", {rdy, ovr_err});
    end
    idle(B);
    drive_frame(8'h33, 1'b1, -1, 10 * B);
    model_frame(8'h33, 1'b1, 1'b0);
    idle(B);
    fork
      drive_frame(8'h44, 1'b1, -1, 10 * B);
      begin
        repeat (LAT) @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
      end
    join
    model_frame(8'h44, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({rx_data, rdy, frm_err, ovr_err} !== {m_data, m_rdy, m_frm, m_ovr}) begin
      n_bad++;
      $display("FAIL clr_coincident: got %h expected %h", {rx_data, rdy, frm_err, ovr_err}, {m_data, m_rdy, m_frm, m_ovr});
    end
    pulse_clr();
    idle(B);
  endtask

  task automatic test_false_start();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      RX = 1'b0;
    end
    idle(2 * B);
    n_cmp++;
    if ({rdy, frm_err, ovr_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL false_start: got %b expected 000", {rdy, frm_err, ovr_err});
    end
    drive_frame(8'h96, 1'b1, -1, 10 * B);
    model_frame(8'h96, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({rx_data, rdy} !== {m_data, m_rdy}) begin
      n_bad++;
      $display("FAIL false_start_next: got %h expected %h", {rx_data, rdy}, {m_data, m_rdy});
    end
    pulse_clr();
    idle(B);
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         skip;
    for (int k = 0; k < 10; k++) begin
      b    = 8'($urandom_range(0, 255));
      skip = ($urandom_range(0, 3) == 0);
      drive_frame(b, 1'b1, -1, 10 * B);
      model_frame(b, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++;
      if ({rx_data, rdy, frm_err, ovr_err} !== {m_data, m_rdy, m_frm, m_ovr}) begin
        n_bad++;
        $display("FAIL random_%0d: got %h expected %h", k, {rx_data, rdy, frm_err, ovr_err}, {m_data, m_rdy, m_frm, m_ovr});
      end
      if (!skip) pulse_clr();
      idle($urandom_range(0, B));
    end
    pulse_clr();
    idle(B);
  endtask

  task automatic test_reset_midframe();
    drive_frame(8'hC3, 1'b1, -1, 10 * B);
    model_frame(8'hC3, 1'b1, 1'b0);
    idle(B);
    drive_frame(8'h69, 1'b1, -1, 5 * B);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rx_data, rdy, frm_err, ovr_err} !== 11'h0) begin
      n_bad++;
      $display("FAIL reset_midframe: got %h expected %h", {rx_data, rdy, frm_err, ovr_err}, 11'h0);
    end
    model_clr();
    m_data = 8'h00;
    @(negedge clk);
    RX = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      RX = 1'b0;
    end
    idle(12 * B);
    n_cmp++;
    if ({rx_data, rdy, frm_err, ovr_err} !== 11'h0) begin
      n_bad++;
      $display("FAIL reset_stale_frame: got %h expected %h", {rx_data, rdy, frm_err, ovr_err}, 11'h0);
    end
    drive_frame(8'h5A, 1'b1, (MAJ != 0) ? (4 * B + H) : -1, 10 * B);
    model_frame(8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({rx_data, rdy, frm_err, ovr_err} !== {m_data, m_rdy, m_frm, m_ovr}) begin
      n_bad++;
      $display("FAIL reset_next_byte: got %h expected %h", {rx_data, rdy, frm_err, ovr_err}, {m_data, m_rdy, m_frm, m_ovr});
    end
    pulse_clr();
    idle(B);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_framing();
    test_overrun();
    test_false_start();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, LSB first, idle-high line. Mates with the team's UART transmitter at the same baud.
- Synchronizes asynchronous RX, qualifies the start bit and samples each bit at its centre.
- Presents the received byte with a rdy/clr_rdy handshake, plus sticky framing and overrun flags.
- Sits between the pin and the command/host logic.

Parameters:
- BAUD_CNT, 5208: clocks per bit (50 MHz / 9600 baud). Legal range 8 to 8191.
- HALF_CNT, BAUD_CNT/2 (truncated): clocks from the start-bit falling edge to the start-bit centre.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- RX  input  1  serial line, asynchronous, idle high
- clr_rdy  input  1  one-cycle pulse from the consumer: byte taken, clears rdy and the error flags
- rx_data  output  8  last received byte
- rdy  output  1  byte valid; held until clr_rdy
- frm_err  output  1  sticky: stop bit sampled low
- ovr_err  output  1  sticky: a byte completed while rdy was still 1

Behaviour:
- Reset values: rx_data=0x00, rdy=0, frm_err=0, ovr_err=0, state=IDLE. Both RX synchronizer flops preset to 1, so no false start leaves reset.
- RX passes through 2 flops (rx_s) before any use. A falling edge is detected one stage later.
- 13-bit baud counter: cleared on entry to each state, increments every cycle while not IDLE.
- bit_cnt (4 bits) counts sampled data bits 0..8. The 8-bit shift register shifts right with rx_s into bit 7, so 8 shifts leave the first bit in bit 0.
- IDLE: on a rx_s 1->0 transition, go to START and clear the baud counter.
- START: at baud count HALF_CNT-1, sample rx_s.
  - rx_s=1: false start (glitch). Return to IDLE with no flag change.
  - rx_s=0: go to DATA and clear the counter.
- DATA: at each baud count BAUD_CNT-1, shift in rx_s, increment bit_cnt and clear the counter. After the 8th shift, go to STOP.
- STOP: at baud count BAUD_CNT-1, sample rx_s.
  - Stop bit = 1: next cycle rx_data <= shift register and rdy <= 1. If rdy was already 1, ovr_err <= 1; the new byte overwrites the old one. Return to IDLE.
  - Stop bit = 0: frm_err <= 1. rx_data and rdy are unchanged and the byte is discarded. Go to WAIT_HI.
- WAIT_HI: stay until rx_s=1, then go to IDLE. A break or stuck-low line never produces repeated frames.
- clr_rdy: next cycle, rdy, frm_err and ovr_err go to 0.
- Simultaneous clr_rdy and byte completion: the new byte wins. rdy=1, ovr_err is not set, and the flags are then cleared except any flag set by this completion.
- Latency: rdy rises 2 (sync) + 1 (edge) + HALF_CNT + 9*BAUD_CNT + 1 clocks after the RX falling edge at the pin, to within ±1 clock.
- Back-to-back frames with no idle gap after the stop bit must be received. IDLE is re-entered before the stop bit ends.
- rst_n asserted mid-frame: everything returns to reset values immediately and the partial byte is lost. After release, a frame whose start edge has already passed is ignored until the line has been seen high and then falls again.
- rx_data is stable whenever rdy=1, except on overrun.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each start, data and stop sample is a 2-of-3 majority of rx_s at baud counts centre-1, centre and centre+1, where centre is HALF_CNT-1 or BAUD_CNT-1. The decision and counter clear occur at centre+1, so the whole frame slips by 1 clock; rdy latency is +1. A single-clock glitch at the centre does not corrupt a bit.
- Not defined: a single sample at the centre count as above, with no extra flops.

Test Plan:
- BAUD_CNT=32. Send 0xA5 with a clean frame -> rx_data=0xA5 and rdy=1 at edge+2+1+16+288+1 clocks (±1). frm_err=0, ovr_err=0. clr_rdy pulse -> rdy=0 next cycle.
- 0x00 then 0xFF back-to-back with no idle gap, clr_rdy after each -> both bytes captured correctly, no flags.
- Send 0x3C with the stop bit driven low, then hold RX low 100 clocks -> frm_err=1, rdy=0, rx_data unchanged. No second frame is decoded until RX returns high.
- Send 0x11, no clr_rdy, then 0x22 -> rx_data=0x22, rdy=1, ovr_err=1. clr_rdy clears both flags. Also check clr_rdy coincident with completion -> rdy=1, ovr_err=0.
- RX low pulse of 5 clocks -> false start. State returns to IDLE, rdy=0, no flags.
- Assert rst_n mid-byte (after bit 3) -> all outputs 0 at once. The next clean 0x5A after release is received correctly. With UART_RX_MAJORITY_EN, a 1-clock inverted glitch at a data-bit centre still yields 0x5A.
